// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, format codes, default width, decoded-field bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32i_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   localparam logic [2:0] FMT_R    = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
   localparam logic [2:0] FMT_NONE = 3'd7;

   // Width-independent decoded fields; PC and immediate travel separately since they scale with XLEN.
   typedef struct packed {
      logic [6:0] opcode;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [2:0] funct3;
      logic [6:0] funct7;
      logic [2:0] fmt;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational RV32I field extraction, format classification, immediate generation, illegal check.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage owns all flow control.
module decode_fields
   import rv32i_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int ILL_CHECK = 1
) (
   input  logic [31:0]     i_inst,
   output dec_t            o_dec,
   output logic [XLEN-1:0] o_imm
);

   logic [6:0]  w_op;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [2:0]  w_fmt;
   logic [31:0] w_imm32;
   logic        w_ill;

   assign w_op = i_inst[6:0];
   assign w_f3 = i_inst[14:12];
   assign w_f7 = i_inst[31:25];

   // Classify the instruction format from the opcode alone.
   always_comb begin
      w_fmt = FMT_NONE;
      case (w_op)
         OP_OP:                                        w_fmt = FMT_R;
         OP_LOAD, OP_OPIMM, OP_JALR, OP_SYSTEM, OP_FENCE: w_fmt = FMT_I;
         OP_STORE:                                     w_fmt = FMT_S;
         OP_BRANCH:                                    w_fmt = FMT_B;
         OP_LUI, OP_AUIPC:                             w_fmt = FMT_U;
         OP_JAL:                                       w_fmt = FMT_J;
         default:                                      w_fmt = FMT_NONE;
      endcase
   end

   // Assemble the 32-bit immediate for the detected format; R and unknown formats carry zero.
   always_comb begin
      w_imm32 = '0;
      case (w_fmt)
         FMT_I: w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
         FMT_S: w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
         FMT_B: w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
         FMT_U: w_imm32 = {i_inst[31:12], 12'b0};
         FMT_J: w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
         default: w_imm32 = '0;
      endcase
   end

   // Flag encodings outside RV32I: bad quadrant, unknown opcode, reserved funct3/funct7 combinations.
   always_comb begin
      w_ill = 1'b0;
      if (i_inst[1:0] != 2'b11 || w_fmt == FMT_NONE) w_ill = 1'b1;
      case (w_op)
         OP_LOAD:   if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) w_ill = 1'b1;
         OP_STORE:  if (w_f3 > 3'b010) w_ill = 1'b1;
         OP_BRANCH: if (w_f3 == 3'b010 || w_f3 == 3'b011) w_ill = 1'b1;
         OP_JALR:   if (w_f3 != 3'b000) w_ill = 1'b1;
         OP_OP: begin
            if (w_f7 != 7'b0000000 && w_f7 != 7'b0100000) w_ill = 1'b1;
            else if (w_f7 == 7'b0100000 && w_f3 != 3'b000 && w_f3 != 3'b101) w_ill = 1'b1;
         end
         OP_OPIMM: begin
            if (w_f3 == 3'b001 && w_f7 != 7'b0000000) w_ill = 1'b1;
            else if (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000) w_ill = 1'b1;
         end
         default: ;
      endcase
   end

   assign o_dec = '{opcode:  w_op,
                    rd:      i_inst[11:7],
                    rs1:     i_inst[19:15],
                    rs2:     i_inst[24:20],
                    funct3:  w_f3,
                    funct7:  w_f7,
                    fmt:     w_fmt,
                    illegal: (ILL_CHECK != 0) ? w_ill : 1'b0};

   // U-type already places bit 31 at the top, so one sign extension covers every format.
   assign o_imm = XLEN'(signed'(w_imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready on both sides; DECODE_SKID_EN adds a 1-entry skid buffer.
// Latency: 1 cycle in -> out; full throughput, push and pop in the same cycle need no bubble.
// Backpressure: base in_ready = !out_valid | out_ready; with DECODE_SKID_EN in_ready = !skid_valid (registered).
module decode_stage
   import rv32i_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int ILL_CHECK = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      out_opcode,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [2:0]      out_fmt,
   output logic [XLEN-1:0] out_imm,
   output logic            out_illegal
);

   dec_t            w_dec;
   logic [XLEN-1:0] w_imm;
   logic            w_push;
   logic            w_pop;

   logic            r_out_vld;
   dec_t            r_out_dec;
   logic [XLEN-1:0] r_out_pc;
   logic [XLEN-1:0] r_out_imm;

   decode_fields #(.XLEN(XLEN), .ILL_CHECK(ILL_CHECK)) u_fields (
      .i_inst (in_inst),
      .o_dec  (w_dec),
      .o_imm  (w_imm)
   );

   // A flush cycle swallows any offered instruction.
   assign w_push = in_valid & in_ready & ~flush;
   assign w_pop  = r_out_vld & out_ready;

`ifdef DECODE_SKID_EN
   logic            r_skid_vld;
   dec_t            r_skid_dec;
   logic [XLEN-1:0] r_skid_pc;
   logic [XLEN-1:0] r_skid_imm;

   assign in_ready = ~r_skid_vld;

   // Output register refills from skid first to keep order; a push during an output stall parks in skid.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_vld  <= 1'b0;
         r_out_dec  <= '0;
         r_out_pc   <= '0;
         r_out_imm  <= '0;
         r_skid_vld <= 1'b0;
         r_skid_dec <= '0;
         r_skid_pc  <= '0;
         r_skid_imm <= '0;
      end else if (flush) begin
         r_out_vld  <= 1'b0;
         r_skid_vld <= 1'b0;
      end else if (!r_out_vld || w_pop) begin
         if (r_skid_vld) begin
            // in_ready is low while skid is full, so no push can coincide here.
            r_out_vld  <= 1'b1;
            r_out_dec  <= r_skid_dec;
            r_out_pc   <= r_skid_pc;
            r_out_imm  <= r_skid_imm;
            r_skid_vld <= 1'b0;
         end else begin
            r_out_vld <= w_push;
            if (w_push) begin
               r_out_dec <= w_dec;
               r_out_pc  <= in_pc;
               r_out_imm <= w_imm;
            end
         end
      end else if (w_push) begin
         r_skid_vld <= 1'b1;
         r_skid_dec <= w_dec;
         r_skid_pc  <= in_pc;
         r_skid_imm <= w_imm;
      end
   end
`else
   assign in_ready = ~r_out_vld | out_ready;

   // Single output register: load on push (also covers pop+push reload), clear valid on a bare pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_vld <= 1'b0;
         r_out_dec <= '0;
         r_out_pc  <= '0;
         r_out_imm <= '0;
      end else if (flush) begin
         r_out_vld <= 1'b0;
      end else if (w_push) begin
         r_out_vld <= 1'b1;
         r_out_dec <= w_dec;
         r_out_pc  <= in_pc;
         r_out_imm <= w_imm;
      end else if (w_pop) begin
         r_out_vld <= 1'b0;
      end
   end
`endif

   assign out_valid   = r_out_vld;
   assign out_pc      = r_out_pc;
   assign out_opcode  = r_out_dec.opcode;
   assign out_rd      = r_out_dec.rd;
   assign out_rs1     = r_out_dec.rs1;
   assign out_rs2     = r_out_dec.rs2;
   assign out_funct3  = r_out_dec.funct3;
   assign out_funct7  = r_out_dec.funct7;
   assign out_fmt     = r_out_dec.fmt;
   assign out_imm     = r_out_imm;
   assign out_illegal = r_out_dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, stall/flush/reset sequences, short random stream.
// Latency: expects each accepted instruction one cycle later on the output.
// Backpressure: in_ready expectations differ between base and DECODE_SKID_EN builds.
module tb_decode_stage;

   localparam int XLEN = 32;
   localparam int NV   = 18;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [6:0]      out_opcode;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [2:0]      out_funct3;
   logic [6:0]      out_funct7;
   logic [2:0]      out_fmt;
   logic [XLEN-1:0] out_imm;
   logic            out_illegal;

   logic [31:0] v_inst [NV];
   logic [2:0]  v_fmt  [NV];
   logic [31:0] v_imm  [NV];
   logic        v_ill  [NV];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(XLEN), .ILL_CHECK(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_inst     (in_inst),
      .in_pc       (in_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_opcode  (out_opcode),
      .out_rd      (out_rd),
      .out_rs1     (out_rs1),
      .out_rs2     (out_rs2),
      .out_funct3  (out_funct3),
      .out_funct7  (out_funct7),
      .out_fmt     (out_fmt),
      .out_imm     (out_imm),
      .out_illegal (out_illegal)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vec(input int k, input logic [31:0] inst, input logic [2:0] fmt,
                          input logic [31:0] imm, input logic ill);
      v_inst[k] = inst;
      v_fmt[k]  = fmt;
      v_imm[k]  = imm;
      v_ill[k]  = ill;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] t_inst;
      logic [31:0] pc_next;
      int          q_pc  [$];
      int          q_idx [$];
      int          n_in;
      int          n_out;
      int          idx;

      //         inst           fmt  imm            illegal
      set_vec( 0, 32'hFFC1A283, 3'd1, 32'hFFFFFFFC, 1'b0); // lw x5,-4(x3)
      set_vec( 1, 32'hFE51AE23, 3'd2, 32'hFFFFFFFC, 1'b0); // sw x5,-4(x3)
      set_vec( 2, 32'hFE51CCE3, 3'd3, 32'hFFFFFFF8, 1'b0); // blt x3,x5,-8
      set_vec( 3, 32'h123450B7, 3'd4, 32'h12345000, 1'b0); // lui x1,0x12345
      set_vec( 4, 32'h00000000, 3'd7, 32'h00000000, 1'b1); // all zero
      set_vec( 5, 32'h00003083, 3'd1, 32'h00000000, 1'b1); // ld x1,0(x0)
      set_vec( 6, 32'h00000033, 3'd0, 32'h00000000, 1'b0); // add x0,x0,x0
      set_vec( 7, 32'h40001033, 3'd0, 32'h00000000, 1'b1); // funct7=0100000 with sll
      set_vec( 8, 32'h00001067, 3'd1, 32'h00000000, 1'b1); // jalr funct3=001
      set_vec( 9, 32'h40001013, 3'd1, 32'h00000400, 1'b1); // slli with funct7=0100000
      set_vec(10, 32'h40005013, 3'd1, 32'h00000400, 1'b0); // srai x0,x0,0
      set_vec(11, 32'hFFDFF0EF, 3'd5, 32'hFFFFFFFC, 1'b0); // jal x1,-4
      set_vec(12, 32'hFE51BE23, 3'd2, 32'hFFFFFFFC, 1'b1); // store funct3=011
      set_vec(13, 32'h0000000F, 3'd1, 32'h00000000, 1'b0); // fence
      set_vec(14, 32'h00000011, 3'd7, 32'h00000000, 1'b1); // quadrant 01
      set_vec(15, 32'h00002063, 3'd3, 32'h00000000, 1'b1); // branch funct3=010
      set_vec(16, 32'h40000033, 3'd0, 32'h00000000, 1'b0); // sub x0,x0,x0
      set_vec(17, 32'h02000033, 3'd0, 32'h00000000, 1'b1); // mul (M extension)

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
      tick();
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_pc",    out_pc,    0);
      chk("rst_out_imm",   out_imm,   0);
      chk("rst_opcode",    out_opcode, 0);
      rst = 1'b0;

      // Back-to-back decode of every vector with downstream always ready.
      out_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         in_valid = 1'b1;
         in_inst  = v_inst[i];
         in_pc    = 32'h1000 + 32'(4 * i);
         tick();
         t_inst = v_inst[i];
         chk($sformatf("vld[%0d]", i),    out_valid,   1);
         chk($sformatf("pc[%0d]", i),     out_pc,      32'h1000 + 32'(4 * i));
         chk($sformatf("fmt[%0d]", i),    out_fmt,     v_fmt[i]);
         chk($sformatf("imm[%0d]", i),    out_imm,     v_imm[i]);
         chk($sformatf("ill[%0d]", i),    out_illegal, v_ill[i]);
         chk($sformatf("op[%0d]", i),     out_opcode,  t_inst[6:0]);
         chk($sformatf("f7[%0d]", i),     out_funct7,  t_inst[31:25]);
         if (i == 0) begin
            chk("lw_rd", out_rd, 5);
            chk("lw_rs1", out_rs1, 3);
            chk("lw_rs2", out_rs2, 28);
            chk("lw_f3", out_funct3, 2);
         end
         if (i == 1) begin
            chk("sw_rs1", out_rs1, 3);
            chk("sw_rs2", out_rs2, 5);
         end
         if (i == 3) chk("lui_rd", out_rd, 1);
      end
      in_valid = 1'b0;
      tick();
      chk("drain_vld", out_valid, 0);

      // Stall: A lands, B offered while output is blocked.
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = v_inst[0]; in_pc = 32'h2000;
      tick();
      chk("stall_a_vld", out_valid, 1);
      chk("stall_a_pc", out_pc, 32'h2000);
      in_inst = v_inst[1]; in_pc = 32'h2004;
      #1;
`ifdef DECODE_SKID_EN
      chk("stall_rdy_b", in_ready, 1);
`else
      chk("stall_rdy_b", in_ready, 0);
`endif
      tick();
      chk("stall_hold_pc1", out_pc, 32'h2000);
      chk("stall_hold_imm1", out_imm, v_imm[0]);
      chk("stall_rdy1", in_ready, 0);
`ifdef DECODE_SKID_EN
      in_valid = 1'b0;
`endif
      tick();
      chk("stall_hold_pc2", out_pc, 32'h2000);
      chk("stall_rdy2", in_ready, 0);
      out_ready = 1'b1;
      tick();
      chk("stall_b_vld", out_valid, 1);
      chk("stall_b_pc", out_pc, 32'h2004);
      chk("stall_b_fmt", out_fmt, 3'd2);
      in_valid = 1'b0;
      tick();
      chk("stall_empty", out_valid, 0);

      // Flush with entries held and a new instruction offered in the flush cycle.
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = v_inst[0]; in_pc = 32'h3000;
      tick();
      in_inst = v_inst[1]; in_pc = 32'h3004;
      tick();
      in_inst = v_inst[2]; in_pc = 32'h3008; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_vld", out_valid, 0);
      chk("flush_rdy", in_ready, 1);
      out_ready = 1'b1;
      tick();
      chk("flush_after1", out_valid, 0);
      tick();
      chk("flush_after2", out_valid, 0);
      // Flush on an empty stage with a ready-to-accept input.
      in_valid = 1'b1; in_inst = v_inst[3]; in_pc = 32'h300C; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_empty_vld", out_valid, 0);

      // Reset in the middle of a stall with an input offered.
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = v_inst[0]; in_pc = 32'h4000;
      tick();
      in_inst = v_inst[11]; in_pc = 32'h4004;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("mrst_vld", out_valid, 0);
      chk("mrst_rdy", in_ready, 1);
      chk("mrst_pc", out_pc, 0);
      chk("mrst_imm", out_imm, 0);
      chk("mrst_rd", out_rd, 0);
      chk("mrst_ill", out_illegal, 0);
      out_ready = 1'b1;
      tick();
      chk("mrst_after", out_valid, 0);

      // Random stream against an in-order queue of accepted instructions.
      pc_next = 32'h8000;
      n_in = 0;
      n_out = 0;
      for (int cyc = 0; cyc < 330; cyc++) begin
         if (cyc < 300) begin
            idx       = int'($urandom_range(0, NV - 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            idx       = 0;
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         in_inst = v_inst[idx];
         in_pc   = pc_next;
         #1;
         if (out_valid && out_ready) begin
            if (q_pc.size() == 0) begin
               chk("stream_spurious", 1, 0);
            end else begin
               chk("stream_pc",  out_pc,      q_pc[0]);
               chk("stream_imm", out_imm,     v_imm[q_idx[0]]);
               chk("stream_fmt", out_fmt,     v_fmt[q_idx[0]]);
               chk("stream_ill", out_illegal, v_ill[q_idx[0]]);
               void'(q_pc.pop_front());
               void'(q_idx.pop_front());
               n_out++;
            end
         end
         if (in_valid && in_ready) begin
            q_pc.push_back(int'(pc_next));
            q_idx.push_back(idx);
            pc_next = pc_next + 32'd4;
            n_in++;
         end
         tick();
      end
      chk("stream_left", q_pc.size(), 0);
      chk("stream_count", n_out, n_in);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
